uart_rx_deframe: RTL and testbench

//  Receive-side front end of the UART peripheral.
//  - Oversamples the serial rx_in line and deserialises 8N1 frames (start, 8 data LSB first, stop).
//  - Buffers received frames in a small show-ahead FIFO.
//  - Feeds the 10-bit frame word and status to the UART register datapath downstream, which pops one entry per read.

---
 rtl/uart_rx_deframe_if.sv | 50 +++++
 rtl/uart_rx_deframe.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_rx_deframe.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_deframe_if.sv
// -----------------------------------------------------------------------------
// uart_rx_deframe_if
// Bundles the configuration, serial line and downstream register-side signals
// of the UART receive front end.
//
//   baud_div   master->slave  clocks per oversample tick (0 and 1: every clock)
//   rx_en      master->slave  receiver enable
//   rx_in      master->slave  asynchronous serial line, idle high
//   rd_en      master->slave  pop FIFO head (one-cycle pulse)
//   clr_err    master->slave  clear sticky frame_err / overrun
//   rx_d       slave->master  FIFO head {stop, data[7:0], start}, 0 when empty
//   rx_valid   slave->master  FIFO not empty
//   fifo_cnt   slave->master  FIFO occupancy
//   busy       slave->master  receiver FSM not idle
//   frame_err  slave->master  sticky: stop bit received as 0
//   overrun    slave->master  sticky: frame dropped on full FIFO
//   dbg_state  slave->master  receiver FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
//
// Handshake: rx_valid is the valid and rd_en acts as ready; one entry moves
// downstream on every rising clk edge where rx_valid and rd_en are both high.
// rd_en with rx_valid low has no effect. rx_d is stable while rx_valid is high
// and no transfer occurs.
// -----------------------------------------------------------------------------
interface uart_rx_deframe_if #(
  parameter int BAUD_W = 16,
  parameter int CNT_W  = 3
);
  logic [BAUD_W-1:0] baud_div;
  logic              rx_en;
  logic              rx_in;
  logic              rd_en;
  logic              clr_err;
  logic [9:0]        rx_d;
  logic              rx_valid;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              busy;
  logic              frame_err;
  logic              overrun;
  logic [1:0]        dbg_state;

  modport master (
    output baud_div, rx_en, rx_in, rd_en, clr_err,
    input  rx_d, rx_valid, fifo_cnt, busy, frame_err, overrun, dbg_state
  );

  modport slave (
    input  baud_div, rx_en, rx_in, rd_en, clr_err,
    output rx_d, rx_valid, fifo_cnt, busy, frame_err, overrun, dbg_state
  );
endinterface

// File: rtl/uart_rx_deframe.sv
// -----------------------------------------------------------------------------
// uart_rx_deframe
// Receive front end of the UART: synchronises and oversamples rx_in,
// deserialises 8N1 frames and buffers them in a show-ahead FIFO that the
// register datapath pops one entry per read.
//
// Ports:
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   uart_rx_deframe_if.slave (config, serial line, FIFO read side,
//         sticky status, debug state)
// -----------------------------------------------------------------------------
module uart_rx_deframe #(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_W     = 16
) (
  input logic              clk,
  input logic              rst,
  uart_rx_deframe_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int N_W   = $clog2(OVERSAMPLE);
  localparam logic [N_W-1:0]   N_HALF = N_W'(OVERSAMPLE / 2 - 1);
  localparam logic [N_W-1:0]   N_FULL = N_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              rx_meta_q, rx_meta_d;
  logic              rx_sync_q, rx_sync_d;
  logic              rx_prev_q, rx_prev_d;
  logic [BAUD_W-1:0] div_q, div_d;
  logic [BAUD_W-1:0] tcnt_q, tcnt_d;
  logic [BAUD_W-1:0] tcnt_term;
  logic              tick;
  logic [N_W-1:0]    n_q, n_d;
  logic [2:0]        k_q, k_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              push_q, push_d;
  logic [9:0]        frame_q, frame_d;
  logic              busy_q, busy_d;
  logic [9:0]        mem_q [FIFO_DEPTH];
  logic [9:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              full, rd_fire, wr_ok, ferr_set, ovr_set;

  // Two-flop synchroniser plus one more stage for falling-edge detection.
  always_comb begin
    rx_meta_d = bus.rx_in;
    rx_sync_d = rx_meta_q;
    rx_prev_d = rx_sync_q;
  end

  // Oversample tick generator. The divisor is latched only in IDLE and at a
  // counter wrap, so a baud_div change never shortens or stretches a tick
  // already in progress.
  always_comb begin
    tcnt_term = (div_q > BAUD_W'(1)) ? (div_q - BAUD_W'(1)) : '0;
    tick      = (tcnt_q == tcnt_term);
    div_d     = div_q;
    tcnt_d    = tcnt_q;
    if (state_q == S_IDLE || tick) begin
      tcnt_d = '0;
      div_d  = bus.baud_div;
    end else begin
      tcnt_d = tcnt_q + BAUD_W'(1);
    end
  end

  // Receiver FSM.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    shreg_d = shreg_q;
    frame_d = frame_q;
    push_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.rx_en && !rx_sync_q && rx_prev_q) begin
          state_d = S_START;
          n_d     = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (n_q == N_HALF) begin
            // Mid start bit: a line already back high was a glitch.
            n_d = '0;
            k_d = '0;
            state_d = rx_sync_q ? S_IDLE : S_DATA;
          end else begin
            n_d = n_q + N_W'(1);
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (n_q == N_FULL) begin
            n_d     = '0;
            shreg_d = {rx_sync_q, shreg_q[7:1]};  // LSB arrives first
            k_d     = k_q + 3'd1;
            if (k_q == 3'd7) state_d = S_STOP;
          end else begin
            n_d = n_q + N_W'(1);
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (n_q == N_FULL) begin
            n_d     = '0;
            frame_d = {rx_sync_q, shreg_q, 1'b0};
            push_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            n_d = n_q + N_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Disabling the receiver abandons any partial frame.
    if (!bus.rx_en) begin
      state_d = S_IDLE;
      push_d  = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  // FIFO and sticky status. A push into a full FIFO still lands when the
  // head is popped in the same cycle: the slot being written is the one the
  // reader is vacating.
  always_comb begin
    full     = (cnt_q == CNT_FULL);
    rd_fire  = bus.rd_en && (cnt_q != '0);
    wr_ok    = push_q && (!full || rd_fire);
    ferr_set = push_q && !frame_q[9];
    ovr_set  = push_q && full && !rd_fire;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_ok) begin
      mem_d[wr_ptr_q] = frame_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (wr_ok && !rd_fire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!wr_ok && rd_fire) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    // Set has priority over clear.
    ferr_d = (ferr_q && !bus.clr_err) || ferr_set;
    ovr_d  = (ovr_q && !bus.clr_err) || ovr_set;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      div_q     <= '0;
      tcnt_q    <= '0;
      n_q       <= '0;
      k_q       <= '0;
      shreg_q   <= '0;
      push_q    <= 1'b0;
      frame_q   <= '0;
      busy_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
      rx_prev_q <= rx_prev_d;
      div_q     <= div_d;
      tcnt_q    <= tcnt_d;
      n_q       <= n_d;
      k_q       <= k_d;
      shreg_q   <= shreg_d;
      push_q    <= push_d;
      frame_q   <= frame_d;
      busy_q    <= busy_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bus.rx_d      = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign bus.rx_valid  = (cnt_q != '0);
  assign bus.fifo_cnt  = cnt_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_deframe.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deframe
// Self-checking bench for uart_rx_deframe. Serial frames are bit-banged on
// rx_in; the expected FIFO word for each accepted frame goes into exp_q when
// the frame is driven and is compared when the entry is popped.
// -----------------------------------------------------------------------------
module tb_uart_rx_deframe;

  logic clk;
  logic rst;

  uart_rx_deframe_if #(.BAUD_W(16), .CNT_W(3)) bus ();

  uart_rx_deframe #(
    .OVERSAMPLE(16),
    .FIFO_DEPTH(4),
    .BAUD_W    (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [9:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    logic [15:0] div;
    logic [9:0]  exp_d;
    logic        exp_ferr;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int bclk(input logic [15:0] div);
    if (div < 16'd2) return 16;
    return 16 * int'(div);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_frame(input logic [7:0] data, input logic stop,
                            input int bit_clks, input logic expect_it);
    logic [9:0] w;
    w = {stop, data, 1'b0};
    if (expect_it) exp_q.push_back(w);
    for (int i = 0; i < 10; i++) begin
      bus.rx_in = w[i];
      repeat (bit_clks) @(negedge clk);
    end
    bus.rx_in = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!bus.rx_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, " rx_valid"}, 32'(bus.rx_valid), 32'd1);
  endtask

  task automatic pop_check(input string name);
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty, actual rx_d=%0h required none", name, bus.rx_d);
    end else begin
      e = exp_q.pop_front();
      check({name, " valid"}, 32'(bus.rx_valid), 32'd1);
      check({name, " rx_d"}, 32'(bus.rx_d), 32'(e));
    end
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- test ----------------
  initial begin
    int wait_n;
    logic [7:0] rdata;
    logic [15:0] rdiv;

    vecs[0] = '{8'hA5, 1'b1, 16'd1, 10'h34A, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 16'd1, 10'h078, 1'b1};
    vecs[2] = '{8'h00, 1'b1, 16'd1, 10'h200, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 16'd2, 10'h3FE, 1'b0};
    vecs[4] = '{8'h5A, 1'b1, 16'd3, 10'h2B4, 1'b0};
    vecs[5] = '{8'h96, 1'b1, 16'd0, 10'h32C, 1'b0};

    rst         = 1'b0;
    bus.rx_in   = 1'b1;
    bus.rx_en   = 1'b0;
    bus.baud_div = 16'd1;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst rx_d", 32'(bus.rx_d), 32'h0);
    check("rst rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst fifo_cnt", 32'(bus.fifo_cnt), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst frame_err", 32'(bus.frame_err), 32'd0);
    check("rst overrun", 32'(bus.overrun), 32'd0);

    rst = 1'b1;
    bus.rx_en = 1'b1;
    repeat (4) @(negedge clk);

    // Table-driven single frames at several baud divisors
    for (int i = 0; i < NV; i++) begin
      bus.baud_div = vecs[i].div;
      exp_q.push_back(vecs[i].exp_d);
      send_frame(vecs[i].data, vecs[i].stop, bclk(vecs[i].div), 1'b0);
      wait_valid($sformatf("vec%0d", i));
      check($sformatf("vec%0d frame_err", i), 32'(bus.frame_err), 32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d fifo_cnt", i), 32'(bus.fifo_cnt), 32'd1);
      pop_check($sformatf("vec%0d pop", i));
      check($sformatf("vec%0d empty", i), 32'(bus.fifo_cnt), 32'd0);
      pulse_clr();
      check($sformatf("vec%0d clr frame_err", i), 32'(bus.frame_err), 32'd0);
    end

    // Random frames
    for (int i = 0; i < 3; i++) begin
      rdata = 8'($urandom_range(0, 255));
      rdiv  = 16'($urandom_range(1, 2));
      bus.baud_div = rdiv;
      send_frame(rdata, 1'b1, bclk(rdiv), 1'b1);
      wait_valid($sformatf("rnd%0d", i));
      pop_check($sformatf("rnd%0d pop", i));
    end
    bus.baud_div = 16'd1;

    // Start-bit glitch aborts back to IDLE
    bus.rx_in = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch busy high", 32'(bus.busy), 32'd1);
    bus.rx_in = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch busy low", 32'(bus.busy), 32'd0);
    check("glitch fifo_cnt", 32'(bus.fifo_cnt), 32'd0);

    // rx_en low mid-frame aborts the frame
    bus.rx_in = 1'b0;
    repeat (48) @(negedge clk);
    check("rxen busy high", 32'(bus.busy), 32'd1);
    bus.rx_en = 1'b0;
    @(negedge clk);
    check("rxen busy low", 32'(bus.busy), 32'd0);
    check("rxen dbg_state", 32'(bus.dbg_state), 32'd0);
    bus.rx_in = 1'b1;
    repeat (4) @(negedge clk);
    bus.rx_en = 1'b1;
    repeat (200) @(negedge clk);
    check("rxen fifo_cnt", 32'(bus.fifo_cnt), 32'd0);

    // Fill past capacity: fifth frame dropped, overrun set
    for (int d = 1; d <= 5; d++) begin
      send_frame(8'(d), 1'b1, 16, (d <= 4));
    end
    check("ovr fifo_cnt", 32'(bus.fifo_cnt), 32'd4);
    check("ovr overrun", 32'(bus.overrun), 32'd1);
    check("ovr frame_err", 32'(bus.frame_err), 32'd0);
    for (int i = 0; i < 4; i++) pop_check($sformatf("ovr pop%0d", i));
    check("ovr drained cnt", 32'(bus.fifo_cnt), 32'd0);
    check("ovr drained valid", 32'(bus.rx_valid), 32'd0);
    check("ovr drained rx_d", 32'(bus.rx_d), 32'h0);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    @(negedge clk);
    check("empty rd_en cnt", 32'(bus.fifo_cnt), 32'd0);
    pulse_clr();
    check("ovr cleared", 32'(bus.overrun), 32'd0);

    // Full FIFO, pop on the same cycle as a push
    for (int d = 1; d <= 4; d++) send_frame(8'(d), 1'b1, 16, 1'b1);
    check("sim full cnt", 32'(bus.fifo_cnt), 32'd4);
    fork
      send_frame(8'h06, 1'b1, 16, 1'b1);
      begin
        wait_n = 0;
        while (!bus.busy && wait_n < 400) begin @(negedge clk); wait_n++; end
        while (bus.busy && wait_n < 400) begin @(negedge clk); wait_n++; end
        check("sim busy fell", 32'(bus.busy), 32'd0);
        pop_check("sim pop head");
      end
    join
    check("sim cnt", 32'(bus.fifo_cnt), 32'd4);
    check("sim overrun", 32'(bus.overrun), 32'd0);
    for (int i = 0; i < 4; i++) pop_check($sformatf("sim pop%0d", i));

    // Asynchronous reset mid-DATA discards FIFO, flags and partial frame
    send_frame(8'hF0, 1'b0, 16, 1'b0);
    wait_valid("pre-rst");
    check("pre-rst frame_err", 32'(bus.frame_err), 32'd1);
    bus.rx_in = 1'b0;
    repeat (64) @(negedge clk);
    check("pre-rst busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    bus.rx_in = 1'b1;
    #1;
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst cnt", 32'(bus.fifo_cnt), 32'd0);
    check("rst valid", 32'(bus.rx_valid), 32'd0);
    check("rst ferr", 32'(bus.frame_err), 32'd0);
    check("rst rx_d mid", 32'(bus.rx_d), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst hold busy%0d", i), 32'(bus.busy), 32'd0);
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h55, 1'b1, 16, 1'b1);
    wait_valid("post-rst");
    check("post-rst cnt", 32'(bus.fifo_cnt), 32'd1);
    pop_check("post-rst pop");
    check("post-rst empty", 32'(bus.fifo_cnt), 32'd0);

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
